// File: rtl/sw_debounce.sv
// sw_debounce: conditions raw switch pins into a clean switch word.
// Each bit passes a two-flop synchronizer and a tick-sampled stability
// filter; rise/fall pulses and sticky change flags accompany every
// accepted level change. All outputs come straight from flops.
module sw_debounce #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] pin_sw_i,
  input  logic [WIDTH-1:0] chg_clr_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_rise_o,
  output logic [WIDTH-1:0] sw_fall_o,
  output logic [WIDTH-1:0] sw_chg_o,
  output logic             tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic                     tick;
  logic                     tick_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         sw_q, sw_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic [WIDTH-1:0]         chg_q, chg_d;

  // Two-flop synchronizer; runs independently of the enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler: wraps every TICK_DIV enabled cycles; frozen while disabled.
  always_comb begin
    tick   = en_i && (pcnt_q == PMAX);
    pcnt_d = pcnt_q;
    if (en_i) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
  end

  // Per-bit stability filter plus edge pulses and sticky change flags.
  always_comb begin
    cnt_d  = cnt_q;
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    if (tick) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == sw_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CMAX) begin
          cnt_d[i]  = '0;
          sw_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Set takes priority over a simultaneous clear.
    chg_d = (chg_q & ~chg_clr_i) | rise_d | fall_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick;
      cnt_q  <= cnt_d;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign sw_o      = sw_q;
  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
  assign sw_chg_o  = chg_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce: directed sequences, a vector table and a
// randomized run checked every cycle against a behavioural model.
module tb_sw_debounce;

  localparam int unsigned W  = 16;
  localparam int unsigned TD = 4;
  localparam int unsigned SC = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] pin;
  logic [W-1:0] clr;
  logic [W-1:0] sw_o, sw_rise_o, sw_fall_o, sw_chg_o;
  logic         tick_o;

  int unsigned n_tests;
  int unsigned n_fail;
  bit          mon_on;

  sw_debounce #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_CNT(SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .pin_sw_i  (pin),
    .chg_clr_i (clr),
    .sw_o      (sw_o),
    .sw_rise_o (sw_rise_o),
    .sw_fall_o (sw_fall_o),
    .sw_chg_o  (sw_chg_o),
    .tick_o    (tick_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits until (sw_o & mask) == val; n = cycles waited.
  task automatic wait_sw(input logic [W-1:0] mask, input logic [W-1:0] val,
                         input int unsigned maxc, output int unsigned n, output bit ok);
    n  = 0;
    ok = 0;
    while (n < maxc) begin
      step();
      n++;
      if ((sw_o & mask) === (val & mask)) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Behavioural model: pins are seen by the filter two edges late, a tick
  // falls on every TD-th enabled cycle, and a bit flips after SC
  // consecutive ticks that disagree with the current output.
  logic [W-1:0] m_sw, m_rise, m_fall, m_chg, m_p1, m_p2, m_acc;
  logic         m_tick, m_t;
  int unsigned  m_phase;
  int unsigned  m_run [W];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sw = '0; m_rise = '0; m_fall = '0; m_chg = '0;
      m_p1 = '0; m_p2 = '0; m_tick = 1'b0; m_phase = 0;
      for (int unsigned i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_t   = en && ((m_phase % TD) == TD - 1);
      m_acc = '0;
      if (m_t) begin
        for (int unsigned i = 0; i < W; i++) begin
          if (m_p2[i] != m_sw[i]) begin
            m_run[i]++;
            if (m_run[i] == SC) begin
              m_acc[i] = 1'b1;
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_rise = m_acc & ~m_sw;
      m_fall = m_acc & m_sw;
      m_sw   = m_sw ^ m_acc;
      m_chg  = (m_chg & ~clr) | m_acc;
      m_tick = m_t;
      if (en) m_phase++;
      m_p2 = m_p1;
      m_p1 = pin;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_sw",   sw_o,      m_sw);
      chk("mon_rise", sw_rise_o, m_rise);
      chk("mon_fall", sw_fall_o, m_fall);
      chk("mon_chg",  sw_chg_o,  m_chg);
      chk("mon_tick", tick_o,    m_tick);
      chk("mon_rise_fall_excl", sw_rise_o & sw_fall_o, '0);
    end
  end

  typedef struct {
    logic         en;
    logic [W-1:0] pin;
    logic [W-1:0] clr;
    int unsigned  hold;
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_chg;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, ticks;
    bit          ok, bad;

    vecs[0] = '{1'b1, 16'hA5A5, 16'hFFFF,  2, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b1, 16'h0F0F, 16'h0000, 20, 16'h0F0F, 16'hAAAA};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 20, 16'h0F0F, 16'hAAAA};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 20, 16'hFFFF, 16'hFAFA};
    vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF,  1, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, 16'h0000, 16'h0000,  2, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b1, 16'h0000, 16'h0000, 20, 16'h0000, 16'hFFFF};
    vecs[7] = '{1'b1, 16'h1234, 16'h0000, 20, 16'h1234, 16'hFFFF};

    n_tests = 0; n_fail = 0; mon_on = 0;
    rst_n = 1'b0; en = 1'b1; pin = 16'hFFFF; clr = '0;

    // Reset with all pins high, then latency to the first accepted word.
    repeat (3) begin
      step();
      mon_on = 1;
      chk("rst_sw",   sw_o,      '0);
      chk("rst_rise", sw_rise_o, '0);
      chk("rst_fall", sw_fall_o, '0);
      chk("rst_chg",  sw_chg_o,  '0);
      chk("rst_tick", tick_o,    '0);
    end
    rst_n = 1'b1;
    wait_sw(16'hFFFF, 16'hFFFF, 20, n, ok);
    chk("rst_lat_ok", ok, 1);
    chk("rst_lat_range", (n >= 11 && n <= 14), 1);
    chk("rst_rise_pulse", sw_rise_o, 16'hFFFF);
    chk("rst_chg_set", sw_chg_o, 16'hFFFF);
    step();
    chk("rst_rise_end", sw_rise_o, '0);

    pin = '0;
    wait_sw(16'hFFFF, 16'h0000, 20, n, ok);
    chk("settle0_ok", ok, 1);
    clr = 16'hFFFF; step(); clr = '0;
    chk("settle0_clr", sw_chg_o, '0);

    // Stable press on bit 0.
    pin = 16'h0001;
    wait_sw(16'h0001, 16'h0001, 20, n, ok);
    chk("press_ok", ok, 1);
    chk("press_lat_range", (n >= 11 && n <= 14), 1);
    chk("press_sw", sw_o, 16'h0001);
    chk("press_rise", sw_rise_o, 16'h0001);
    step();
    chk("press_rise_end", sw_rise_o, '0);

    // 6-cycle glitch on bit 5 must never get through.
    bad = 0;
    pin = 16'h0021;
    repeat (6) begin
      step();
      bad |= sw_o[5] | sw_rise_o[5] | sw_fall_o[5] | sw_chg_o[5];
    end
    pin = 16'h0001;
    repeat (20) begin
      step();
      bad |= sw_o[5] | sw_rise_o[5] | sw_fall_o[5] | sw_chg_o[5];
    end
    chk("glitch_rejected", bad, 0);

    // Release, fall pulse, clear, then set-wins-over-clear.
    pin = '0;
    wait_sw(16'h0001, 16'h0000, 20, n, ok);
    chk("release_ok", ok, 1);
    chk("release_fall", sw_fall_o, 16'h0001);
    chk("release_rise", sw_rise_o, '0);
    step();
    chk("release_fall_end", sw_fall_o, '0);
    clr = 16'h0001; step(); clr = '0;
    chk("clear_chg0", sw_chg_o[0], 0);
    clr = 16'h0001;
    pin = 16'h0001;
    bad = 0;
    n = 0;
    ok = 0;
    while (n < 20) begin
      step();
      n++;
      if (sw_o[0] === 1'b1) begin
        ok = 1;
        break;
      end
      bad |= sw_chg_o[0];
    end
    chk("setwin_ok", ok, 1);
    chk("setwin_pre_clear", bad, 0);
    chk("setwin_chg", sw_chg_o[0], 1);
    step();
    chk("setwin_then_clear", sw_chg_o[0], 0);
    clr = '0;

    // Freeze: no ticks and no output motion while disabled.
    en = 1'b0;
    bad = 0;
    repeat (2) step();
    for (int unsigned k = 0; k < 21; k++) begin
      if (k % 3 == 0) pin = pin ^ 16'h0008;
      step();
      bad |= tick_o | (sw_o !== 16'h0001);
    end
    pin = 16'h0009;
    repeat (6) begin
      step();
      bad |= tick_o | (sw_o !== 16'h0001);
    end
    chk("freeze_quiet", bad, 0);
    en = 1'b1;
    ticks = 0;
    n = 0;
    ok = 0;
    while (n < 20) begin
      step();
      n++;
      if (tick_o === 1'b1) ticks++;
      if (sw_o[3] === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk("freeze_resume_ok", ok, 1);
    chk("freeze_resume_ticks", ticks, 3);

    // All A5A5 bits accepted together.
    pin = '0;
    wait_sw(16'hFFFF, 16'h0000, 20, n, ok);
    chk("settle1_ok", ok, 1);
    clr = 16'hFFFF; step(); clr = '0;
    pin = 16'hA5A5;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (sw_o !== 16'h0000) break;
    end
    chk("simul_sw", sw_o, 16'hA5A5);
    chk("simul_rise", sw_rise_o, 16'hA5A5);
    chk("simul_fall", sw_fall_o, '0);

    // Vector table.
    for (int unsigned v = 0; v < 8; v++) begin
      en  = vecs[v].en;
      pin = vecs[v].pin;
      clr = vecs[v].clr;
      repeat (vecs[v].hold) step();
      chk($sformatf("vec%0d_sw", v),  sw_o,     vecs[v].exp_sw);
      chk($sformatf("vec%0d_chg", v), sw_chg_o, vecs[v].exp_chg);
    end
    clr = '0;
    en  = 1'b1;

    // Randomized run; the monitor compares against the model each cycle.
    for (int unsigned k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) pin = pin ^ W'($urandom & $urandom);
      en    = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    en    = 1'b1;
    clr   = '0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage between the board switch pins and the GPIO peripheral's switch-read port. Each switch bit goes through a two-flop synchronizer and a tick-based stability filter. The block then presents a clean, glitch-free switch word that the GPIO returns on reads of 0x5000_0000. It also produces per-bit rise/fall pulses and sticky change flags for a future interrupt or polling path.

## Interface
- WIDTH, 16, number of switch bits.
- TICK_DIV, 1000, clock cycles per sample tick; legal range ≥ 2.
- STABLE_CNT, 4, consecutive differing ticks required to accept a new level; legal range ≥ 1.
- clk  in  1  system clock; every flop updates on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en_i  in  1  filter enable; when low, the prescaler and the filter freeze.
- pin_sw_i  in  WIDTH  raw asynchronous switch pins.
- chg_clr_i  in  WIDTH  per-bit clear of the sticky change flags; level-sensitive.
- sw_o  out  WIDTH  debounced switch word; drives the GPIO switch input.
- sw_rise_o  out  WIDTH  one-cycle pulse per bit when sw_o goes 0→1.
- sw_fall_o  out  WIDTH  one-cycle pulse per bit when sw_o goes 1→0.
- sw_chg_o  out  WIDTH  sticky flag per bit, set on any accepted change.
- tick_o  out  1  one-cycle sample strobe; exported for test and debug.

## Operation
- **Synchronizer**
  - sync1 <= pin_sw_i; sync2 <= sync1.
  - Runs regardless of en_i.
  - Reset value 0.
- **Prescaler**
  - Counter pcnt, width clog2(TICK_DIV).
  - While en_i = 1: pcnt increments each cycle and wraps from TICK_DIV-1 to 0.
  - tick is high while pcnt == TICK_DIV-1 and en_i = 1.
  - tick_o is registered: it is high for the one cycle after that condition.
  - en_i = 0: pcnt holds its value and no ticks are generated.
- **Per-bit filter**
  - Each bit i has a counter cnt[i], width max(1, clog2(STABLE_CNT)).
  - The following rules are evaluated only on a tick cycle:
    - sync2[i] == sw_o[i]: cnt[i] <= 0. This restarts the filter and rejects glitches.
    - sync2[i] != sw_o[i] and cnt[i] == STABLE_CNT-1: sw_o[i] <= sync2[i], cnt[i] <= 0.
    - sync2[i] != sw_o[i] otherwise: cnt[i] <= cnt[i]+1.
  - With STABLE_CNT = 1, the first differing tick is accepted.
  - Non-tick cycles: sw_o and cnt hold their values.
- **Edge pulses**
  - sw_rise_o[i] and sw_fall_o[i] are registered alongside sw_o.
  - Each is high for exactly the one cycle in which sw_o first shows the new value.
  - Both are low in all other cycles.
  - A bit never has both rise and fall asserted together.
- **Sticky flags**
  - Clear: sw_chg_o[i] <= 0 when chg_clr_i[i] = 1.
  - Set: sw_chg_o[i] <= 1 in the same edge that updates sw_o[i].
  - Set and clear in the same cycle: set wins.
- **Reset**
  - Values: sync1, sync2, pcnt, all cnt, sw_o, sw_rise_o, sw_fall_o, sw_chg_o and tick_o are all 0.
  - Mid-operation reset discards any partial filter count.
  - A switch held high through reset reappears after the normal latency, with a rise pulse.

## Timing
- Pin to sync2: 2 cycles.
- sw_o update: on the STABLE_CNT-th consecutive tick at which sync2 differs from sw_o.
  - Worst case from a stable pin change: 2 + STABLE_CNT·TICK_DIV cycles.
  - Best case: 2 + (STABLE_CNT-1)·TICK_DIV + 1 cycles.
- Glitch rejection: a pin excursion shorter than (STABLE_CNT-1)·TICK_DIV cycles never reaches sw_o.
- Outputs: all outputs are registered, with no combinational path from any input.
- Freeze: toggling en_i low and back high resumes pcnt and cnt exactly where they stopped.

## Test plan
Bench parameters: WIDTH=16, TICK_DIV=4, STABLE_CNT=3.
- **Reset:** hold rst_n=0 for 3 cycles with pin_sw_i=16'hFFFF → all outputs 0 through reset. After release, sw_o=16'hFFFF after the latency bound of 2+3·4 cycles, together with sw_rise_o=16'hFFFF for 1 cycle and sw_chg_o=16'hFFFF.
- **Stable press:** set pin_sw_i[0] 0→1 and hold → sw_o[0]=1 between cycles 11 and 14 after the change; sw_rise_o[0] high for exactly 1 cycle; other bits unchanged.
- **Glitch:** pulse pin_sw_i[5] high for 6 cycles → sw_o[5] stays 0, with no rise or fall pulse and no sw_chg_o[5].
- **Release and clear:** after the press in the stable-press test, drop the pin → sw_fall_o[0] pulses once. Then assert chg_clr_i[0] for 1 cycle → sw_chg_o[0]=0. Assert chg_clr_i[0] on the same cycle as a new accepted change → sw_chg_o[0]=1.
- **Freeze:** hold en_i=0 while pin_sw_i[3] toggles → tick_o stays 0 and sw_o is frozen. Set en_i=1 → sw_o[3] updates only after 3 further ticks.
- **Simultaneous bits:** set pin_sw_i=16'hA5A5 at once → sw_o=16'hA5A5 on a single edge, with rise pulses on exactly those bits.
